// File: rtl/regfile_ctrl_pkg.sv
// rtl/regfile_ctrl_pkg.sv - shared widths and requester indices for the regfile write scheduler
package regfile_ctrl_pkg;
  localparam int REG_W    = 16;
  localparam int REG_AW   = 3;
  localparam int NUM_REGS = 8;

  localparam int REQ_ALU  = 0;
  localparam int REQ_LOAD = 1;
  localparam int REQ_TRAP = 2;
endpackage

// File: rtl/regfile_wb_scheduler_if.sv
// rtl/regfile_wb_scheduler_if.sv - writeback request and destination reservation bundle
interface regfile_wb_scheduler_if #(
  parameter int NUM_REQ = 3
);
  import regfile_ctrl_pkg::*;

  logic [NUM_REQ-1:0]        req_valid;
  logic [REG_AW*NUM_REQ-1:0] req_dr;
  logic [REG_W*NUM_REQ-1:0]  req_data;
  logic [NUM_REQ-1:0]        req_ready;

  logic              rsv_valid;
  logic [REG_AW-1:0] rsv_dr;
  logic              rsv_ready;

  modport master (
    output req_valid, req_dr, req_data, rsv_valid, rsv_dr,
    input  req_ready, rsv_ready
  );

  modport slave (
    input  req_valid, req_dr, req_data, rsv_valid, rsv_dr,
    output req_ready, rsv_ready
  );
endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter: one-hot grant and winner index, pointer moves past the winner
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  localparam int PW = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] valid,
  output logic [NUM_REQ-1:0] grant,
  output logic [PW-1:0]      winner
);
  logic [PW-1:0] ptr_q, ptr_d;
  logic          found;
  int            idx;

  always_comb begin
    grant  = '0;
    winner = ptr_q;
    found  = 1'b0;
    idx    = 0;
    ptr_d  = ptr_q;
    // Search order starts at the pointer and wraps; first valid requester wins.
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && !reset && valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        winner     = PW'(idx);
      end
    end
    if (found) begin
      ptr_d = (winner == PW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
endmodule

// File: rtl/regfile_wb_scheduler.sv
// rtl/regfile_wb_scheduler.sv - shares the regfile write port among requesters, tracks busy destinations, raises stall
// Optional same-cycle forwarding of the landing write: REGFILE_BYPASS_EN.
module regfile_wb_scheduler
  import regfile_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  regfile_wb_scheduler_if.slave bus,
  input  logic [REG_AW-1:0]     SR1,
  input  logic [REG_AW-1:0]     SR2,
  output logic                  stall,
  output logic                  regWE,
  output logic [REG_AW-1:0]     DR,
  output logic [REG_W-1:0]      Buss
`ifdef REGFILE_BYPASS_EN
  ,
  output logic                  fwd_a_sel,
  output logic [REG_W-1:0]      fwd_a,
  output logic                  fwd_b_sel,
  output logic [REG_W-1:0]      fwd_b
`endif
);
  localparam int PW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]  grant;
  logic [PW-1:0]       win;
  logic                regwe_q, regwe_d;
  logic [REG_AW-1:0]   dr_q, dr_d;
  logic [REG_W-1:0]    buss_q, buss_d;
  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                rsv_ok;
  logic                hit_a, hit_b;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk    (clk),
    .reset  (reset),
    .valid  (bus.req_valid),
    .grant  (grant),
    .winner (win)
  );

  assign bus.req_ready = grant;
  assign rsv_ok        = ~busy_q[bus.rsv_dr];
  assign bus.rsv_ready = rsv_ok;

  assign regWE = regwe_q;
  assign DR    = dr_q;
  assign Buss  = buss_q;

  always_comb begin
    regwe_d = |grant;
    dr_d    = dr_q;
    buss_d  = buss_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (regwe_d && int'(win) == i) begin
        dr_d   = bus.req_dr[REG_AW*i +: REG_AW];
        buss_d = bus.req_data[REG_W*i +: REG_W];
      end
    end
  end

  // Clear first so a new reservation on the landing register overrides it.
  always_comb begin
    busy_d = busy_q;
    if (regwe_q) busy_d[dr_q] = 1'b0;
    if (bus.rsv_valid && rsv_ok) busy_d[bus.rsv_dr] = 1'b1;
  end

`ifdef REGFILE_BYPASS_EN
  assign hit_a     = regwe_q && (dr_q == SR1);
  assign hit_b     = regwe_q && (dr_q == SR2);
  assign fwd_a_sel = hit_a;
  assign fwd_a     = buss_q;
  assign fwd_b_sel = hit_b;
  assign fwd_b     = buss_q;
`else
  assign hit_a = 1'b0;
  assign hit_b = 1'b0;
`endif

  assign stall = !reset && ((busy_q[SR1] && !hit_a) || (busy_q[SR2] && !hit_b));

  always_ff @(posedge clk) begin
    if (reset) begin
      regwe_q <= 1'b0;
      dr_q    <= '0;
      buss_q  <= '0;
      busy_q  <= '0;
    end else begin
      regwe_q <= regwe_d;
      dr_q    <= dr_d;
      buss_q  <= buss_d;
      busy_q  <= busy_d;
    end
  end
endmodule
